// File: rtl/cic_comb_mc_pkg.sv
// Shared channelizer definitions: default widths, sample type and clog2 helper.
package cic_comb_mc_pkg;

  localparam int unsigned CHZ_DATA_W   = 24;
  localparam int unsigned CHZ_NUM_CHAN = 256;

  typedef logic [CHZ_DATA_W-1:0] sample_t;

  // Address/index width for a count of v items; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned w = 1; w < v; w = w << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cic_comb_mc_if.sv
// Sample stream bus for the comb stage: input stream, bypass control, output stream.
interface cic_comb_mc_if import cic_comb_mc_pkg::*; #(
  parameter int unsigned DATA_W   = CHZ_DATA_W,
  parameter int unsigned NUM_CHAN = CHZ_NUM_CHAN
) ();
  localparam int unsigned CHAN_W = clog2(NUM_CHAN);

  logic              bypass;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [CHAN_W-1:0] m_chan;
  logic              sync_err;

  modport master (
    output bypass, s_valid, s_data, s_last,
    input  m_valid, m_data, m_last, m_chan, sync_err
  );

  modport slave (
    input  bypass, s_valid, s_data, s_last,
    output m_valid, m_data, m_last, m_chan, sync_err
  );
endinterface

// File: rtl/cic_delay_ram.sv
// Simple dual-port delay-line RAM, synchronous read-first; contents are not reset.
module cic_delay_ram import cic_comb_mc_pkg::*; #(
  parameter int unsigned DATA_W = CHZ_DATA_W,
  parameter int unsigned DEPTH  = CHZ_NUM_CHAN
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [clog2(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [clog2(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the word stored before this cycle's write to the same address.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/cic_comb_mc.sv
// Time-multiplexed CIC comb: y[n,ch] = x[n,ch] - x[n-DIFF_DELAY,ch] over an
// interleaved NUM_CHAN stream, with frame-sync checking, priming and bypass.
module cic_comb_mc import cic_comb_mc_pkg::*; #(
  parameter int unsigned DATA_W     = CHZ_DATA_W,
  parameter int unsigned NUM_CHAN   = CHZ_NUM_CHAN,
  parameter int unsigned DIFF_DELAY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cic_comb_mc_if.slave bus
);
  localparam int unsigned DEPTH  = NUM_CHAN * DIFF_DELAY;
  localparam int unsigned CHAN_W = clog2(NUM_CHAN);
  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              accept;
  logic [CHAN_W-1:0] chan;
  logic [ADDR_W-1:0] ptr;
  logic              primed;
  logic              at_last;
  logic              frame_err;
  logic [DATA_W-1:0] ram_q;

  // S0 stage
  logic              v0, last0, err0, use_ram0;
  logic [DATA_W-1:0] x0;
  logic [CHAN_W-1:0] chan0;
  // S1 stage
  logic              v1, last1, err1;
  logic [DATA_W-1:0] diff1;
  logic [CHAN_W-1:0] chan1;

  assign accept = bus.s_valid;

  // Frame-sync check against the local channel counter.
  always_comb begin
    at_last   = (chan == LAST_CHAN);
    frame_err = (bus.s_last != at_last);
  end

  // Channel counter, delay-line pointer and priming state.
  // A sync error returns the counter to 0 in both error cases, since an
  // unmarked last channel wraps to 0 anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan   <= '0;
      ptr    <= '0;
      primed <= 1'b0;
    end else if (accept) begin
      chan <= (at_last || frame_err) ? '0 : chan + 1'b1;
      if (frame_err) begin
        ptr    <= '0;
        primed <= 1'b0;
      end else if (ptr == LAST_ADDR) begin
        ptr    <= '0;
        primed <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  cic_delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (ptr),
    .wr_data (bus.s_data),
    .rd_en   (accept),
    .rd_addr (ptr),
    .rd_data (ram_q)
  );

  // S0: capture the sample and its tags alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0       <= 1'b0;
      x0       <= '0;
      chan0    <= '0;
      last0    <= 1'b0;
      err0     <= 1'b0;
      use_ram0 <= 1'b0;
    end else begin
      v0 <= accept;
      if (accept) begin
        x0       <= bus.s_data;
        chan0    <= chan;
        last0    <= at_last;
        err0     <= frame_err;
        use_ram0 <= primed && !bus.bypass;
      end
    end
  end

  // S1: subtract the delayed sample (zero while unprimed or bypassed), modulo 2^DATA_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      diff1 <= '0;
      chan1 <= '0;
      last1 <= 1'b0;
      err1  <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        diff1 <= x0 - (use_ram0 ? ram_q : '0);
        chan1 <= chan0;
        last1 <= last0;
        err1  <= err0;
      end
    end
  end

  // S2: output register; data and channel hold across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.m_last   <= 1'b0;
      bus.m_chan   <= '0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.m_valid  <= v1;
      bus.m_last   <= v1 && last1;
      bus.sync_err <= v1 && err1;
      if (v1) begin
        bus.m_data <= diff1;
        bus.m_chan <= chan1;
      end
    end
  end
endmodule

// File: tb/tb_cic_comb_mc.sv
// Scoreboard bench: two comb instances (4 ch / N=1 and 2 ch / N=2, 16-bit).
module tb_cic_comb_mc;
  import cic_comb_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_comb_mc_if #(.DATA_W(16), .NUM_CHAN(4)) bus_a ();
  cic_comb_mc_if #(.DATA_W(16), .NUM_CHAN(2)) bus_b ();

  cic_comb_mc #(.DATA_W(16), .NUM_CHAN(4), .DIFF_DELAY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  cic_comb_mc #(.DATA_W(16), .NUM_CHAN(2), .DIFF_DELAY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    logic [15:0]     d;
    int unsigned     ch;
    bit              last;
    bit              err;
    longint unsigned cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int failures = 0;
  longint unsigned cyc = 0;
  logic [15:0] hold_a = '0;
  logic [15:0] hold_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor A: pop and compare on every output beat; check hold behaviour in gaps.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.m_valid) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_valid: got m_valid=1 expected no output");
        end else begin
          ea = qa.pop_front();
          chk("a_data", bus_a.m_data, ea.d);
          chk("a_chan", bus_a.m_chan, ea.ch);
          chk("a_last", bus_a.m_last, ea.last);
          chk("a_sync_err", bus_a.sync_err, ea.err);
          chk("a_latency", cyc, ea.cyc);
          hold_a = ea.d;
        end
      end else begin
        chk("a_hold_data", bus_a.m_data, hold_a);
        chk("a_idle_sync_err", bus_a.sync_err, 0);
        chk("a_idle_last", bus_a.m_last, 0);
      end
    end
  end

  // Monitor B: same checks for the two-channel instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.m_valid) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_valid: got m_valid=1 expected no output");
        end else begin
          eb = qb.pop_front();
          chk("b_data", bus_b.m_data, eb.d);
          chk("b_chan", bus_b.m_chan, eb.ch);
          chk("b_last", bus_b.m_last, eb.last);
          chk("b_sync_err", bus_b.sync_err, eb.err);
          chk("b_latency", cyc, eb.cyc);
          hold_b = eb.d;
        end
      end else begin
        chk("b_hold_data", bus_b.m_data, hold_b);
        chk("b_idle_sync_err", bus_b.sync_err, 0);
        chk("b_idle_last", bus_b.m_last, 0);
      end
    end
  end

  // Present one sample to instance sel (0=A, 1=B) and queue its expected output.
  task automatic send(input bit sel, input logic [15:0] d, input bit last, input bit byp,
                      input logic [15:0] ed, input int unsigned ech, input bit eerr);
    exp_t e;
    e.d    = ed;
    e.ch   = ech;
    e.last = sel ? (ech == 1) : (ech == 3);
    e.err  = eerr;
    e.cyc  = cyc + 3;
    if (!sel) begin
      bus_a.s_valid = 1'b1; bus_a.s_data = d; bus_a.s_last = last; bus_a.bypass = byp;
      qa.push_back(e);
    end else begin
      bus_b.s_valid = 1'b1; bus_b.s_data = d; bus_b.s_last = last; bus_b.bypass = byp;
      qb.push_back(e);
    end
    @(posedge clk); #1;
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Asynchronous reset: outputs must drop at once, in-flight samples are discarded.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_a_m_valid", bus_a.m_valid, 0);
    chk("rst_b_m_valid", bus_b.m_valid, 0);
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.s_last = 1'b0; bus_a.bypass = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.s_last = 1'b0; bus_b.bypass = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // Reset state after idle cycles.
    chk("init_a_valid", bus_a.m_valid, 0);
    chk("init_a_data", bus_a.m_data, 0);
    chk("init_a_chan", bus_a.m_chan, 0);
    chk("init_a_last", bus_a.m_last, 0);
    chk("init_a_sync_err", bus_a.sync_err, 0);
    chk("init_b_valid", bus_b.m_valid, 0);
    chk("init_b_data", bus_b.m_data, 0);
    chk("init_b_sync_err", bus_b.sync_err, 0);

    // Reset mid-stream with samples in flight, then restart at channel 0 unprimed.
    send(0, 16'd1, 0, 0, 16'd1, 0, 0);
    send(0, 16'd2, 0, 0, 16'd2, 1, 0);
    send(0, 16'd3, 0, 0, 16'd3, 2, 0);
    do_reset();
    send(0, 16'd1234, 0, 0, 16'd1234, 0, 0);
    send(0, 16'd55,   0, 0, 16'd55,   1, 0);
    idle(5);

    // Continuous stream, bypass for frames 0-1, differences of 10 afterwards.
    do_reset();
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++)
        send(0, 16'(100*c + 10*k), c == 3, k < 2, (k < 2) ? 16'(100*c + 10*k) : 16'd10, c, 0);
    idle(5);

    // Same stream with random valid gaps: identical outputs.
    do_reset();
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++) begin
        while ($urandom_range(0, 99) < 40) idle(1);
        send(0, 16'(100*c + 10*k), c == 3, k < 2, (k < 2) ? 16'(100*c + 10*k) : 16'd10, c, 0);
      end
    idle(5);

    // Modulo wrap on channel 0.
    do_reset();
    send(0, 16'h7FFF, 0, 0, 16'h7FFF, 0, 0);
    send(0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    send(0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    send(0, 16'h0000, 1, 0, 16'h0000, 3, 0);
    send(0, 16'h8000, 0, 0, 16'h0001, 0, 0);
    send(0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    send(0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    send(0, 16'h0000, 1, 0, 16'h0000, 3, 0);
    send(0, 16'h7FFF, 0, 0, 16'hFFFF, 0, 0);
    idle(5);

    // Frame-sync errors with realignment and re-priming.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        send(0, 16'(100*c + 10*k), c == 3, 0, (k == 0) ? 16'(100*c) : 16'd10, c, 0);
    send(0, 16'd20,  0, 0, 16'd10, 0, 0);
    send(0, 16'd120, 1, 0, 16'd10, 1, 1);   // early s_last on channel 1
    send(0, 16'd500, 0, 0, 16'd500, 0, 0);
    send(0, 16'd600, 0, 0, 16'd600, 1, 0);
    send(0, 16'd700, 0, 0, 16'd700, 2, 0);
    send(0, 16'd800, 1, 0, 16'd800, 3, 0);
    send(0, 16'd510, 0, 0, 16'd10, 0, 0);
    send(0, 16'd610, 0, 0, 16'd10, 1, 0);
    send(0, 16'd710, 0, 0, 16'd10, 2, 0);
    send(0, 16'd810, 1, 0, 16'd10, 3, 0);
    send(0, 16'd520, 0, 0, 16'd10, 0, 0);
    send(0, 16'd620, 0, 0, 16'd10, 1, 0);
    send(0, 16'd720, 0, 0, 16'd10, 2, 0);
    send(0, 16'd820, 0, 0, 16'd10, 3, 1);   // missing s_last on channel 3
    send(0, 16'd900, 0, 0, 16'd900, 0, 0);
    idle(5);

    // Two channels, N=2, with a bypassed frame mid-stream.
    do_reset();
    send(1, 16'd10,  0, 0, 16'd10, 0, 0);
    send(1, 16'd5,   1, 0, 16'd5,  1, 0);
    send(1, 16'd20,  0, 0, 16'd20, 0, 0);
    send(1, 16'd7,   1, 0, 16'd7,  1, 0);
    send(1, 16'd30,  0, 0, 16'd20, 0, 0);
    send(1, 16'd12,  1, 0, 16'd7,  1, 0);
    send(1, 16'd40,  0, 0, 16'd20, 0, 0);
    send(1, 16'd20,  1, 0, 16'd13, 1, 0);
    send(1, 16'd60,  0, 1, 16'd60, 0, 0);
    send(1, 16'd30,  1, 1, 16'd30, 1, 0);
    send(1, 16'd80,  0, 0, 16'd40, 0, 0);
    send(1, 16'd35,  1, 0, 16'd15, 1, 0);
    send(1, 16'd100, 0, 0, 16'd40, 0, 0);
    send(1, 16'd31,  1, 0, 16'd1,  1, 0);
    idle(6);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
